// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared types, cycle-count helper and golden model for the
//            tiled convolution engine.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

    typedef shortreal feature_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    localparam int c_DEF_N = 4;
    localparam int c_DEF_M = 4;
    localparam int c_DEF_K = 2;
    localparam int c_DEF_R = 4;
    localparam int c_DEF_C = 4;

    function automatic int compute_cycles(input int m, input int n, input int r,
                                          input int c, input int k,
                                          input int tm, input int tn);
        return (m / tm) * (n / tn) * r * c * k * k;
    endfunction

    // Same loop order and per-lane summation order as the engine, so results
    // are bit-identical for the default geometry.
    function automatic void golden_conv(
        input  feature_t fm  [c_DEF_N][c_DEF_R][c_DEF_C],
        input  feature_t w   [c_DEF_M][c_DEF_N][c_DEF_K][c_DEF_K],
        input  int       s,
        input  int       tm,
        input  int       tn,
        output feature_t out [c_DEF_M][c_DEF_R][c_DEF_C]
    );
        feature_t acc [c_DEF_M][c_DEF_R][c_DEF_C];
        feature_t sum;
        feature_t x;
        for (int m = 0; m < c_DEF_M; m++)
            for (int r = 0; r < c_DEF_R; r++)
                for (int c = 0; c < c_DEF_C; c++)
                    acc[m][r][c] = 0.0;
        for (int m0 = 0; m0 < c_DEF_M; m0 += tm)
            for (int n0 = 0; n0 < c_DEF_N; n0 += tn)
                for (int r = 0; r < c_DEF_R; r++)
                    for (int c = 0; c < c_DEF_C; c++)
                        for (int i = 0; i < c_DEF_K; i++)
                            for (int j = 0; j < c_DEF_K; j++)
                                for (int m = m0; m < m0 + tm; m++) begin
                                    sum = 0.0;
                                    for (int n = n0; n < n0 + tn; n++) begin
                                        x = 0.0;
                                        if ((s * r + i) < c_DEF_R && (s * c + j) < c_DEF_C)
                                            x = fm[n][s * r + i][s * c + j];
                                        if (n == n0) sum = w[m][n][i][j] * x;
                                        else         sum = sum + w[m][n][i][j] * x;
                                    end
                                    acc[m][r][c] = acc[m][r][c] + sum;
                                end
        out = acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : cnn_mac_array
// Purpose  : Tm x Tn multipliers with an ordered per-lane adder chain.
// Revision : 1.0
// ============================================================================
module cnn_mac_array
    import cnn_pkg::*;
#(
    parameter int Tm_p = 2,
    parameter int Tn_p = 2
) (
    input  feature_t weights_i [Tm_p][Tn_p],
    input  feature_t fm_i      [Tn_p],
    output feature_t psum_o    [Tm_p]
);

    feature_t w_chain [Tm_p][Tn_p];

    // Strict left-to-right chain keeps floating-point rounding reproducible.
    for (genvar gm = 0; gm < Tm_p; gm++) begin : g_lane
        for (genvar gn = 0; gn < Tn_p; gn++) begin : g_tap
            if (gn == 0) begin : g_first
                assign w_chain[gm][gn] = weights_i[gm][gn] * fm_i[gn];
            end else begin : g_rest
                assign w_chain[gm][gn] = w_chain[gm][gn-1] + weights_i[gm][gn] * fm_i[gn];
            end
        end
        assign psum_o[gm] = w_chain[gm][Tn_p-1];
    end

endmodule
`default_nettype wire

// File: rtl/cnn_conv_tile.sv
`default_nettype none
// ============================================================================
// Module   : cnn_conv_tile
// Purpose  : Tiled 2-D convolution engine; snapshots inputs on start and
//            publishes all output maps at once when the loop nest finishes.
// Revision : 1.0
// ============================================================================
module cnn_conv_tile
    import cnn_pkg::*;
#(
    parameter int N_p  = 4,
    parameter int M_p  = 4,
    parameter int K_p  = 2,
    parameter int R_p  = 4,
    parameter int C_p  = 4,
    parameter int S_p  = 1,
    parameter int Tn_p = 2,
    parameter int Tm_p = 2
) (
    input  feature_t fm_i      [N_p][R_p][C_p],
    input  feature_t weights_i [M_p][N_p][K_p][K_p],
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     valid_i,
    output feature_t fm_o      [M_p][R_p][C_p]
);

    localparam int c_MT = M_p / Tm_p;
    localparam int c_NT = N_p / Tn_p;

    if ((M_p % Tm_p) != 0 || (N_p % Tn_p) != 0) begin : g_bad_tile
        $fatal(1, "cnn_conv_tile: tile sizes must divide the map counts");
    end

    state_t   r_state;
    state_t   w_state_nxt;
    logic     r_drain;
    logic     w_start;
    logic     w_mac;
    logic     w_load;
    logic     w_last;
    int       r_mt, r_nt, r_r, r_c, r_i, r_j;
    int       w_row, w_col, w_row_idx, w_col_idx;
    logic     w_inb;

    feature_t r_fm   [N_p][R_p][C_p];
    feature_t r_w    [M_p][N_p][K_p][K_p];
    feature_t r_acc  [M_p][R_p][C_p];
    feature_t w_lane_fm [Tn_p];
    feature_t w_lane_w  [Tm_p][Tn_p];
    feature_t w_psum    [Tm_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // r_drain marks the extra cycle after the final MAC that publishes fm_o.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_mac       = 1'b0;
        w_load      = 1'b0;
        w_last      = (r_mt == c_MT - 1) && (r_nt == c_NT - 1) && (r_r == R_p - 1) &&
                      (r_c == C_p - 1) && (r_i == K_p - 1) && (r_j == K_p - 1);
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_drain) begin
                    w_load      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_mac = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            {r_mt, r_nt, r_r, r_c, r_i, r_j} <= '0;
            r_drain <= 1'b0;
        end else if (w_start) begin
            {r_mt, r_nt, r_r, r_c, r_i, r_j} <= '0;
            r_drain <= 1'b0;
        end else if (w_mac) begin
            if (w_last) r_drain <= 1'b1;
            if (r_j == K_p - 1) begin
                r_j <= 0;
                if (r_i == K_p - 1) begin
                    r_i <= 0;
                    if (r_c == C_p - 1) begin
                        r_c <= 0;
                        if (r_r == R_p - 1) begin
                            r_r <= 0;
                            if (r_nt == c_NT - 1) begin
                                r_nt <= 0;
                                r_mt <= (r_mt == c_MT - 1) ? 0 : r_mt + 1;
                            end else r_nt <= r_nt + 1;
                        end else r_r <= r_r + 1;
                    end else r_c <= r_c + 1;
                end else r_i <= r_i + 1;
            end else r_j <= r_j + 1;
        end else if (w_load) begin
            r_drain <= 1'b0;
        end
    end

    // Bottom/right zero padding; indices are clamped so reads stay in range.
    assign w_row     = S_p * r_r + r_i;
    assign w_col     = S_p * r_c + r_j;
    assign w_inb     = (w_row < R_p) && (w_col < C_p);
    assign w_row_idx = w_inb ? w_row : 0;
    assign w_col_idx = w_inb ? w_col : 0;

    for (genvar gt = 0; gt < Tn_p; gt++) begin : g_fm_sel
        assign w_lane_fm[gt] = w_inb ? r_fm[r_nt * Tn_p + gt][w_row_idx][w_col_idx] : 0.0;
        for (genvar gm = 0; gm < Tm_p; gm++) begin : g_w_sel
            assign w_lane_w[gm][gt] = r_w[r_mt * Tm_p + gm][r_nt * Tn_p + gt][r_i][r_j];
        end
    end

    cnn_mac_array #(
        .Tm_p (Tm_p),
        .Tn_p (Tn_p)
    ) u_mac (
        .weights_i (w_lane_w),
        .fm_i      (w_lane_fm),
        .psum_o    (w_psum)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int m = 0; m < M_p; m++)
                for (int r = 0; r < R_p; r++)
                    for (int c = 0; c < C_p; c++) begin
                        r_acc[m][r][c] <= 0.0;
                        fm_o[m][r][c]  <= 0.0;
                    end
            for (int n = 0; n < N_p; n++)
                for (int r = 0; r < R_p; r++)
                    for (int c = 0; c < C_p; c++)
                        r_fm[n][r][c] <= 0.0;
            for (int m = 0; m < M_p; m++)
                for (int n = 0; n < N_p; n++)
                    for (int i = 0; i < K_p; i++)
                        for (int j = 0; j < K_p; j++)
                            r_w[m][n][i][j] <= 0.0;
        end else begin
            if (w_start) begin
                r_fm <= fm_i;
                r_w  <= weights_i;
                for (int m = 0; m < M_p; m++)
                    for (int r = 0; r < R_p; r++)
                        for (int c = 0; c < C_p; c++)
                            r_acc[m][r][c] <= 0.0;
            end
            if (w_mac) begin
                for (int lm = 0; lm < Tm_p; lm++)
                    r_acc[r_mt * Tm_p + lm][r_r][r_c] <= r_acc[r_mt * Tm_p + lm][r_r][r_c] + w_psum[lm];
            end
            if (w_load) fm_o <= r_acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv_tile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cnn_conv_tile
// Purpose  : Self-checking bench for the default engine and a K=3/S=2 variant.
// Revision : 1.0
// ============================================================================
module tb_cnn_conv_tile;
    import cnn_pkg::*;

    localparam int N = 4, M = 4, R = 4, C = 4, K = 2, KS = 3;
    localparam int T_DEF = 256, T_SWP = 576;

    logic     clk = 1'b0;
    logic     rst;
    logic     valid;
    shortreal fm   [N][R][C];
    shortreal w1   [M][N][K][K];
    shortreal w2   [M][N][KS][KS];
    shortreal out1 [M][R][C];
    shortreal out2 [M][R][C];

    int n_vec = 0, n_err = 0, n_print = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    cnn_conv_tile u_dut (
        .fm_i(fm), .weights_i(w1), .clk_i(clk), .reset_i(rst), .valid_i(valid), .fm_o(out1)
    );

    cnn_conv_tile #(.K_p(3), .S_p(2), .Tm_p(1), .Tn_p(4)) u_swp (
        .fm_i(fm), .weights_i(w2), .clk_i(clk), .reset_i(rst), .valid_i(valid), .fm_o(out2)
    );

    // Direct evaluation of the convolution definition in the stated loop order.
    function automatic void conv_model(input shortreal f [N][R][C], input shortreal w [M][N][KS][KS],
                                       input int k, input int s, input int tm, input int tn,
                                       output shortreal o [M][R][C]);
        shortreal acc [M][R][C];
        shortreal sum, x;
        for (int m = 0; m < M; m++) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) acc[m][r][c] = 0.0;
        for (int m0 = 0; m0 < M; m0 += tm)
            for (int n0 = 0; n0 < N; n0 += tn)
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++)
                                for (int m = m0; m < m0 + tm; m++) begin
                                    sum = 0.0;
                                    for (int n = n0; n < n0 + tn; n++) begin
                                        x = 0.0;
                                        if (s * r + i < R && s * c + j < C) x = f[n][s * r + i][s * c + j];
                                        if (n == n0) sum = w[m][n][i][j] * x;
                                        else         sum = sum + w[m][n][i][j] * x;
                                    end
                                    acc[m][r][c] = acc[m][r][c] + sum;
                                end
        o = acc;
    endfunction

    // Expected outputs: result appears T+1 edges after an accepted start.
    shortreal exp1 [M][R][C], exp2 [M][R][C], res1 [M][R][C], res2 [M][R][C];
    shortreal wx [M][N][KS][KS];
    bit busy1 = 0, busy2 = 0;
    int cd1 = 0, cd2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy1 = 0; busy2 = 0; cd1 = 0; cd2 = 0;
            for (int m = 0; m < M; m++) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
                exp1[m][r][c] = 0.0; exp2[m][r][c] = 0.0;
            end
        end else begin
            if (busy1) begin
                cd1--;
                if (cd1 == 0) begin exp1 = res1; busy1 = 0; end
            end else if (valid) begin
                for (int m = 0; m < M; m++) for (int n = 0; n < N; n++)
                    for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++)
                        wx[m][n][i][j] = (i < K && j < K) ? w1[m][n][i][j] : 0.0;
                conv_model(fm, wx, K, 1, 2, 2, res1);
                cd1 = T_DEF + 1; busy1 = 1;
            end
            if (busy2) begin
                cd2--;
                if (cd2 == 0) begin exp2 = res2; busy2 = 0; end
            end else if (valid) begin
                conv_model(fm, w2, KS, 2, 1, 4, res2);
                cd2 = T_SWP + 1; busy2 = 1;
            end
        end
    end

    task automatic check_arr(input string nm, input shortreal a [M][R][C], input shortreal e [M][R][C]);
        bit bad;
        bad = 0;
        n_vec++;
        for (int m = 0; m < M; m++) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++)
            if (!bad && a[m][r][c] != e[m][r][c]) begin
                bad = 1;
                n_err++;
                if (n_print < 40)
                    $display("FAIL %s [%0d][%0d][%0d] @%0t: got %f, expected %f", nm, m, r, c, $time,
                             a[m][r][c], e[m][r][c]);
                n_print++;
            end
    endtask

    task automatic chk_lit(input string nm, input shortreal a, input shortreal e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %f, expected %f", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_arr("fm_o", out1, exp1);
            check_arr("sweep fm_o", out2, exp2);
        end
    end

    task automatic tick();
        @(negedge clk); #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse();
        valid = 1'b1; tick(); valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy1 || busy2) && k < budget) begin tick(); k++; end
        if (busy1 || busy2) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic set_ramp();
        for (int n = 0; n < N; n++) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++)
            fm[n][r][c] = n + 0.25 * (4 * r + c);
        for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) begin
            for (int i = 0; i < K; i++) for (int j = 0; j < K; j++)
                w1[m][n][i][j] = (i == j) ? (m + 1) * 0.5 : 0.0;
            for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++)
                w2[m][n][i][j] = (i == j) ? (m + 1) * 0.5 : 0.0;
        end
    endtask

    task automatic randomize_fm();
        for (int n = 0; n < N; n++) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++)
            fm[n][r][c] = $urandom_range(0, 15) * 0.25;
    endtask

    shortreal gold [M][R][C];

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid = 1'b0;
        for (int n = 0; n < N; n++) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) fm[n][r][c] = 1.0;
        for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) begin
            for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) w1[m][n][i][j] = 1.0;
            for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++) w2[m][n][i][j] = 1.0;
        end
        ticks(2);
        rst = 1'b0;
        chk_en = 1;
        tick();

        chk_lit("cycles default", shortreal'(compute_cycles(4, 4, 4, 4, 2, 2, 2)), shortreal'(T_DEF));
        chk_lit("cycles sweep", shortreal'(compute_cycles(4, 4, 4, 4, 3, 1, 4)), shortreal'(T_SWP));
        chk_lit("reset fm_o", out1[2][1][3], 0.0);

        // All-ones run: exact completion edge and border values.
        pulse();
        ticks(256);
        chk_lit("ones before E0+257", out1[0][0][0], 0.0);
        tick();
        chk_lit("ones interior", out1[0][0][0], 16.0);
        chk_lit("ones edge col", out1[1][2][3], 8.0);
        chk_lit("ones edge row", out1[3][3][0], 8.0);
        chk_lit("ones corner", out1[2][3][3], 4.0);
        ticks(319);
        chk_lit("sweep before E0+577", out2[0][0][0], 0.0);
        tick();
        chk_lit("sweep [0][0][0]", out2[0][0][0], 36.0);
        chk_lit("sweep [1][1][1]", out2[1][1][1], 16.0);
        chk_lit("sweep [0][0][1]", out2[0][0][1], 24.0);
        chk_lit("sweep pad [3][3][3]", out2[3][3][3], 0.0);
        wait_idle(50);

        // Mid-cycle asynchronous reset clears fm_o at once.
        #3 rst = 1'b1;
        #1 chk_lit("async reset fm_o", out1[1][2][2], 0.0);
        chk_lit("async reset sweep", out2[0][0][0], 0.0);
        tick(); tick();
        rst = 1'b0;
        ticks(300);
        chk_lit("idle hold", out1[0][0][0], 0.0);

        // Ramp inputs, compared with the package golden model too.
        set_ramp();
        pulse();
        wait_idle(700);
        chk_lit("ramp [0][0][0]", out1[0][0][0], 8.5);
        chk_lit("ramp [1][3][3]", out1[1][3][3], 21.0);
        golden_conv(fm, w1, 1, 2, 2, gold);
        check_arr("golden fm_o", out1, gold);

        // Valid held high with inputs changing every cycle.
        valid = 1'b1;
        for (int k = 0; k < 600; k++) begin randomize_fm(); tick(); end
        valid = 1'b0;
        wait_idle(700);

        // Abort at E0+100, then a clean restart.
        randomize_fm();
        pulse();
        ticks(99);
        @(posedge clk); #1 rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_lit("abort fm_o", out1[0][0][0], 0.0);
        set_ramp();
        pulse();
        ticks(100);
        chk_lit("restart partial", out1[0][0][0], 0.0);
        wait_idle(700);
        chk_lit("restart [0][0][0]", out1[0][0][0], 8.5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
